// File: rtl/jogador_tron.sv
// rtl/jogador_tron.sv - light-cycle player: position, steering, collision check and trail painting
module jogador_tron #(
  parameter logic [7:0] ID      = 8'h01,
  parameter int         TAM     = 8,
  parameter int         X0      = 216,
  parameter int         Y0      = 240,
  parameter int         DIR0    = 0,
  parameter int         BORDA   = 16,
  parameter int         H_RES   = 640,
  parameter int         V_RES   = 480,
  parameter int         ADDR_W  = 19,
  parameter int         PERIODO = 2_000_000,
  parameter int         LIMPA   = 1
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              reiniciar,
  input  logic [3:0]        KEY,
  input  logic [7:0]        rd_data,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              wren,
  output logic [9:0]        pos_x,
  output logic [9:0]        pos_y,
  output logic [1:0]        sentido,
  output logic              fim_de_jogo,
  output logic              ocupado
);

  localparam int LOG2 = $clog2(TAM);
  localparam int IW   = 2 * LOG2 + 1;
  localparam int NPIX = TAM * TAM;
  localparam int NFB  = H_RES * V_RES;
  localparam int CW   = (PERIODO > 1) ? $clog2(PERIODO) : 1;

  localparam logic [IW-1:0]     ULT_PIX = IW'(NPIX - 1);
  localparam logic [IW-1:0]     NPIX_V  = IW'(NPIX);
  localparam logic [ADDR_W-1:0] ULT_FB  = ADDR_W'(NFB - 1);
  localparam logic [CW-1:0]     ULT_CNT = CW'(PERIODO - 1);
  localparam logic [10:0]       MIN_B   = 11'(BORDA);
  localparam logic [10:0]       MAX_X   = 11'(H_RES - BORDA - TAM);
  localparam logic [10:0]       MAX_Y   = 11'(V_RES - BORDA - TAM);

  typedef enum logic [2:0] {ST_LIMPA, ST_INICIAL, ST_CORRE, ST_VERIFICA, ST_ESCREVE, ST_FIM} estado_t;
  typedef enum logic {SOLTO, PRESO} volante_t;

  estado_t     estado;
  volante_t    volante;
  logic [CW-1:0]     cnt;
  logic              pend;
  logic [IW-1:0]     idx;
  logic [ADDR_W-1:0] fb_cnt;
  logic [9:0]        cand_x, cand_y;
  logic [9:0]        cand_x_c, cand_y_c;
  logic              legal_c;
  logic              wrap;

  // Pixel i of the block at (bx,by), row-major.
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [9:0] bx, input logic [9:0] by,
                                                 input logic [IW-1:0] i);
    logic [IW-1:0] col, lin;
    col = i & IW'(TAM - 1);
    lin = i >> LOG2;
    return ADDR_W'(bx + 10'(col)) + ADDR_W'(by + 10'(lin)) * ADDR_W'(H_RES);
  endfunction

  assign wrap = (cnt == ULT_CNT);

  // An underflowed coordinate wraps to ~1020 and fails the upper bound.
  always_comb begin
    cand_x_c = pos_x;
    cand_y_c = pos_y;
    case (sentido)
      2'd0:    cand_x_c = pos_x + 10'(TAM);
      2'd1:    cand_y_c = pos_y + 10'(TAM);
      2'd2:    cand_x_c = pos_x - 10'(TAM);
      default: cand_y_c = pos_y - 10'(TAM);
    endcase
    legal_c = ({1'b0, cand_x_c} >= MIN_B) && ({1'b0, cand_x_c} <= MAX_X) &&
              ({1'b0, cand_y_c} >= MIN_B) && ({1'b0, cand_y_c} <= MAX_Y);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset || reiniciar) begin
      estado      <= (LIMPA != 0) ? ST_LIMPA : ST_INICIAL;
      volante     <= SOLTO;
      pos_x       <= 10'(X0);
      pos_y       <= 10'(Y0);
      cand_x      <= 10'(X0);
      cand_y      <= 10'(Y0);
      sentido     <= 2'(DIR0);
      fim_de_jogo <= 1'b0;
      ocupado     <= 1'b1;
      wren        <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      rd_addr     <= '0;
      cnt         <= '0;
      pend        <= 1'b0;
      idx         <= '0;
      fb_cnt      <= '0;
    end else begin
      if (estado != ST_FIM && estado != ST_LIMPA) begin
        if (volante == SOLTO) begin
          if (!KEY[3]) begin
            sentido <= sentido - 2'd1;
            volante <= PRESO;
          end else if (!KEY[2]) begin
            sentido <= sentido + 2'd1;
            volante <= PRESO;
          end
        end else if (KEY == 4'hF) begin
          volante <= SOLTO;
        end
      end

      if (estado == ST_CORRE || estado == ST_VERIFICA || estado == ST_ESCREVE)
        cnt <= wrap ? '0 : cnt + 1'b1;

      case (estado)
        ST_LIMPA: begin
          wren    <= 1'b1;
          wr_data <= 8'd0;
          wr_addr <= fb_cnt;
          fb_cnt  <= fb_cnt + 1'b1;
          if (fb_cnt == ULT_FB) begin
            estado <= ST_INICIAL;
            idx    <= '0;
          end
        end
        ST_INICIAL: begin
          wren    <= 1'b1;
          wr_data <= ID;
          wr_addr <= pix_addr(pos_x, pos_y, idx);
          idx     <= idx + 1'b1;
          if (idx == ULT_PIX) begin
            estado  <= ST_CORRE;
            ocupado <= 1'b0;
          end
        end
        ST_CORRE: begin
          wren <= 1'b0;
          if (wrap || pend) begin
            pend <= 1'b0;
            if (legal_c) begin
              cand_x  <= cand_x_c;
              cand_y  <= cand_y_c;
              rd_addr <= pix_addr(cand_x_c, cand_y_c, '0);
              idx     <= '0;
              estado  <= ST_VERIFICA;
            end else begin
              estado      <= ST_FIM;
              fim_de_jogo <= 1'b1;
            end
          end
        end
        ST_VERIFICA: begin
          // idx counts sampling edges; rd_data holds read idx-1 when idx >= 1.
          if (wrap) pend <= 1'b1;
          if (idx != '0 && rd_data != 8'd0) begin
            estado      <= ST_FIM;
            fim_de_jogo <= 1'b1;
          end else if (idx == NPIX_V) begin
            estado <= ST_ESCREVE;
            idx    <= '0;
          end else begin
            if (idx != ULT_PIX) rd_addr <= pix_addr(cand_x, cand_y, idx + 1'b1);
            idx <= idx + 1'b1;
          end
        end
        ST_ESCREVE: begin
          if (wrap) pend <= 1'b1;
          if (idx == NPIX_V) begin
            wren   <= 1'b0;
            pos_x  <= cand_x;
            pos_y  <= cand_y;
            estado <= ST_CORRE;
          end else begin
            wren    <= 1'b1;
            wr_data <= ID;
            wr_addr <= pix_addr(cand_x, cand_y, idx);
            idx     <= idx + 1'b1;
          end
        end
        default: begin
          wren        <= 1'b0;
          fim_de_jogo <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jogador_tron.sv
// tb/tb_jogador_tron.sv - directed bench for jogador_tron on a 64x48 arena with a RAM model
module tb_jogador_tron;

  localparam int H    = 64;
  localparam int V    = 48;
  localparam int T    = 4;
  localparam int B    = 4;
  localparam int P    = 100;
  localparam int AW   = 12;
  localparam int NFB  = H * V;
  localparam int BUSY = NFB + T * T;
  localparam int LAT  = P + 2 * T * T + 2;

  logic          CLOCK_50 = 1'b0;
  logic          reset;
  logic          reiniciar;
  logic [3:0]    KEY;
  logic [7:0]    rd_data;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [7:0]    wr_data;
  logic          wren;
  logic [9:0]    pos_x, pos_y;
  logic [1:0]    sentido;
  logic          fim_de_jogo, ocupado;

  logic          fill_en   = 1'b0;
  logic          poke_en   = 1'b0;
  logic [AW-1:0] poke_addr = '0;
  logic [7:0]    poke_data = '0;
  logic [7:0]    mem [0:4095];
  int            wr_count  = 0;
  int            checks    = 0;
  int            errors    = 0;

  typedef struct {
    logic [3:0] key;
    int         hold;
    logic [1:0] exp_dir;
  } vec_t;
  vec_t tab [8];

  jogador_tron #(
    .ID(8'h01), .TAM(T), .X0(16), .Y0(16), .DIR0(0), .BORDA(B),
    .H_RES(H), .V_RES(V), .ADDR_W(AW), .PERIODO(P), .LIMPA(1)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .reiniciar(reiniciar), .KEY(KEY),
    .rd_data(rd_data), .rd_addr(rd_addr), .wr_addr(wr_addr), .wr_data(wr_data),
    .wren(wren), .pos_x(pos_x), .pos_y(pos_y), .sentido(sentido),
    .fim_de_jogo(fim_de_jogo), .ocupado(ocupado)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) begin
    if (fill_en) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'hAA;
    end else begin
      if (poke_en) mem[poke_addr] <= poke_data;
      if (wren) begin
        mem[wr_addr] <= wr_data;
        wr_count <= wr_count + 1;
      end
    end
    rd_data <= mem[rd_addr];
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  // Mismatches against "8'h01 inside the rectangle, 0 elsewhere".
  function automatic int ram_diff(input int x0, input int x1, input int y0, input int y1);
    int d = 0;
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) begin
        logic [7:0] e;
        e = (x >= x0 && x <= x1 && y >= y0 && y <= y1) ? 8'h01 : 8'h00;
        if (mem[x + y * H] !== e) d++;
      end
    return d;
  endfunction

  task automatic release_and_wait(output int busy);
    reset = 1'b0;
    reiniciar = 1'b0;
    fill_en = 1'b0;
    busy = 0;
    while (ocupado && busy < NFB + 500) begin
      busy++;
      @(negedge CLOCK_50);
    end
  endtask

  task automatic restart(output int busy);
    KEY = 4'hF;
    reiniciar = 1'b1;
    tick(2);
    release_and_wait(busy);
  endtask

  task automatic wait_step(input string name, output int cyc);
    logic [9:0] ox, oy;
    ox = pos_x;
    oy = pos_y;
    cyc = 0;
    while (pos_x == ox && pos_y == oy && !fim_de_jogo && cyc < 400) begin
      cyc++;
      @(negedge CLOCK_50);
    end
    check({name, " step within bound"}, int'(cyc < 400), 1);
  endtask

  initial begin
    int busy, cyc, w0, bad;

    tab[0] = '{4'b0011, 3, 2'd3};
    tab[1] = '{4'b1011, 3, 2'd0};
    tab[2] = '{4'b1011, 3, 2'd1};
    tab[3] = '{4'b0111, 3, 2'd0};
    tab[4] = '{4'b0111, 3, 2'd3};
    tab[5] = '{4'b1110, 3, 2'd3};
    tab[6] = '{4'b1011, 1, 2'd0};
    tab[7] = '{4'b1101, 3, 2'd0};

    KEY = 4'hF;
    reset = 1'b1;
    reiniciar = 1'b0;
    fill_en = 1'b1;
    @(negedge CLOCK_50);
    check("reset ocupado", ocupado, 1);
    check("reset wren", wren, 0);
    check("reset fim", fim_de_jogo, 0);
    check("reset pos_x", pos_x, 16);
    check("reset pos_y", pos_y, 16);
    check("reset sentido", sentido, 0);
    check("reset wr_addr", wr_addr, 0);
    @(negedge CLOCK_50);
    release_and_wait(busy);
    check("ocupado length", busy, BUSY);
    tick(1);
    check("ram after init", ram_diff(16, 19, 16, 19), 0);

    w0 = wr_count;
    wait_step("first", cyc);
    check("step latency", cyc + 1, LAT);
    check("first step writes", wr_count - w0, T * T);
    check("first pos_x", pos_x, 20);
    check("first pos_y", pos_y, 16);
    check("ram after first step", ram_diff(16, 23, 16, 19), 0);

    KEY = 4'b1011;
    tick(10);
    check("pulse sentido held", sentido, 1);
    KEY = 4'hF;
    tick(5);
    check("pulse sentido released", sentido, 1);
    wait_step("down", cyc);
    check("down pos_x", pos_x, 20);
    check("down pos_y", pos_y, 20);

    restart(busy);
    check("ocupado length reiniciar", busy, BUSY);
    for (int i = 0; i < 8; i++) begin
      KEY = tab[i].key;
      tick(tab[i].hold);
      KEY = 4'hF;
      tick(2);
      check($sformatf("steer vector %0d", i), sentido, tab[i].exp_dir);
    end

    restart(busy);
    KEY = 4'b1011;
    for (int s = 0; s < 3; s++) wait_step("held key", cyc);
    check("held key sentido", sentido, 1);
    check("held key pos_x", pos_x, 16);
    check("held key pos_y", pos_y, 28);
    KEY = 4'b1110;
    tick(3);
    KEY = 4'b1011;
    tick(3);
    check("no turn without full release", sentido, 1);
    KEY = 4'hF;
    tick(2);
    KEY = 4'b1011;
    tick(2);
    check("turn after full release", sentido, 2);
    KEY = 4'hF;

    restart(busy);
    poke_en = 1'b1;
    poke_addr = AW'(24 + 16 * H);
    poke_data = 8'h02;
    tick(1);
    poke_en = 1'b0;
    w0 = wr_count;
    wait_step("pre-collision", cyc);
    check("pre-collision pos_x", pos_x, 20);
    check("pre-collision fim", fim_de_jogo, 0);
    check("pre-collision writes", wr_count - w0, T * T);
    w0 = wr_count;
    wait_step("collision", cyc);
    check("collision fim", fim_de_jogo, 1);
    check("collision pos_x", pos_x, 20);
    check("collision writes", wr_count - w0, 0);
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      KEY = (i % 50 < 10) ? 4'b0011 : 4'hF;
      if (fim_de_jogo !== 1'b1 || wren !== 1'b0) bad++;
      tick(1);
    end
    KEY = 4'hF;
    check("fim held 1000 cycles", bad, 0);
    check("fim keys ignored", sentido, 0);
    check("fim pos frozen", pos_x, 20);
    check("fim no writes", wr_count - w0, 0);

    restart(busy);
    for (int k = 1; k <= 10; k++) begin
      wait_step("border run", cyc);
      check($sformatf("border run pos_x %0d", k), pos_x, 16 + 4 * k);
    end
    wait_step("border", cyc);
    check("border fim", fim_de_jogo, 1);
    check("border last pos_x", pos_x, 56);
    check("border last pos_y", pos_y, 16);

    restart(busy);
    KEY = 4'b1011;
    tick(2);
    KEY = 4'hF;
    cyc = 0;
    while (!wren && cyc < 400) begin
      cyc++;
      tick(1);
    end
    check("reach ESCREVE", int'(cyc < 400), 1);
    tick(3);
    check("mid ESCREVE wren", wren, 1);
    reiniciar = 1'b1;
    tick(1);
    check("reiniciar drops wren", wren, 0);
    check("reiniciar ocupado", ocupado, 1);
    release_and_wait(busy);
    check("ocupado after abort", busy, BUSY);
    tick(1);
    check("ram after abort", ram_diff(16, 19, 16, 19), 0);
    check("abort fim", fim_de_jogo, 0);
    check("abort sentido", sentido, 0);
    check("abort pos_y", pos_y, 16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not reach the end, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
